// File: rtl/flux_sched_pkg.sv
// rtl/flux_sched_pkg.sv - shared types and helpers for the flux round-robin scheduler
package flux_sched_pkg;

  typedef enum logic {IDLE, HOLD} sched_state_e;

  function automatic int tag_width(input int flux);
    return (flux > 1) ? $clog2(flux) : 1;
  endfunction

  // Increment modulo flux without relying on power-of-two wrap.
  function automatic int rr_next(input int ptr, input int flux);
    return (ptr + 1 >= flux) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/flux_rr_pick.sv
// rtl/flux_rr_pick.sv - first ready index at or after ptr, modulo FLUX
module flux_rr_pick #(
  parameter int FLUX      = 2,
  parameter int TAG_WIDTH = 1
) (
  input  logic [FLUX-1:0]      ready,
  input  logic [TAG_WIDTH-1:0] ptr,
  output logic                 valid,
  output logic [TAG_WIDTH-1:0] sel
);

  logic [FLUX-1:0]      rot;
  logic [TAG_WIDTH-1:0] off;
  logic [TAG_WIDTH:0]   sum;

  always_comb begin
    rot   = FLUX'({ready, ready} >> ptr);
    valid = 1'b0;
    off   = '0;
    for (int i = FLUX - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid = 1'b1;
        off   = TAG_WIDTH'(i);
      end
    end
    // Un-rotate: the extra bit keeps ptr+off exact before folding back below FLUX.
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (TAG_WIDTH + 1)'(FLUX)) begin
      sum = sum - (TAG_WIDTH + 1)'(FLUX);
    end
    sel = TAG_WIDTH'(sum);
  end

endmodule

// File: rtl/flux_rr_scheduler.sv
// rtl/flux_rr_scheduler.sv - round-robin flux arbiter with bounded bursts for a shared actor
module flux_rr_scheduler
  import flux_sched_pkg::*;
#(
  parameter int FLUX      = 2,
  parameter int BURST     = 2,
  parameter int TAG_WIDTH = tag_width(FLUX)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [FLUX-1:0]      in_empty,
  input  logic [FLUX-1:0]      out_full,
  output logic                 fire,
  output logic [TAG_WIDTH-1:0] tag,
  output logic [FLUX-1:0]      read,
  output logic                 busy
);

  localparam int CW = $clog2(BURST + 1);

  sched_state_e         state, state_n;
  logic [TAG_WIDTH-1:0] ptr, ptr_n, owner, owner_n, sel;
  logic [CW-1:0]        cnt, cnt_n, cnt_inc;
  logic [FLUX-1:0]      ready;
  logic                 started, go, valid;

  assign ready = ~in_empty & ~out_full;
  // Firing is held off during reset and for the first cycle after it.
  assign go    = en & started & ~rst;

  flux_rr_pick #(
    .FLUX      (FLUX),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_pick (
    .ready (ready),
    .ptr   (ptr),
    .valid (valid),
    .sel   (sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      cnt     <= '0;
      started <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      owner   <= owner_n;
      cnt     <= cnt_n;
      started <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    cnt_n   = cnt;
    fire    = 1'b0;
    tag     = '0;
    cnt_inc = cnt + CW'(1);
    case (state)
      IDLE: begin
        if (go && valid) begin
          fire = 1'b1;
          tag  = sel;
          if (BURST == 1) begin
            ptr_n = TAG_WIDTH'(rr_next(int'(sel), FLUX));
          end else begin
            owner_n = sel;
            cnt_n   = CW'(1);
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (go) begin
          if (ready[owner]) begin
            fire  = 1'b1;
            tag   = owner;
            cnt_n = cnt_inc;
          end
          // A stalled owner gives up the rest of its burst, costing one bubble.
          if (!ready[owner] || cnt_inc == CW'(BURST)) begin
            state_n = IDLE;
            ptr_n   = TAG_WIDTH'(rr_next(int'(owner), FLUX));
            cnt_n   = '0;
          end
        end
      end
      default: ;
    endcase
  end

  assign read = fire ? (FLUX'(1) << tag) : '0;
  assign busy = (state == HOLD) & ~rst;

endmodule
